// File: rtl/pipes.sv
// Shared types and constants for the front-end pipeline stages.
package pipes;

    localparam int XLEN = 64;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 64'h8000_0000;
    localparam logic [31:0]     INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ        = 2'd0,
        HOLD       = 2'd1,
        DISCARD    = 2'd2,
        WAIT_REDIR = 2'd3
    } fetch_state_t;

    // Packet handed to the IF/ID register.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            misalign;
    } fetch_out_t;

    function automatic fetch_out_t make_pkt(input logic [XLEN-1:0] pc,
                                            input logic [31:0] instr,
                                            input logic misalign);
        fetch_out_t p;
        p.valid    = 1'b1;
        p.pc       = pc;
        p.instr    = instr;
        p.misalign = misalign;
        return p;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus: one outstanding request, completion signalled by data_ok.
interface fetch_stage_if;
    logic                   ireq_valid;
    logic [pipes::XLEN-1:0] ireq_addr;
    logic                   iresp_data_ok;
    logic [31:0]            iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding bus
// requests and presents {pc, instr} to the IF/ID register.
//
// state      | meaning
// -----------+---------------------------------------------------------
// REQ        | request at pc on the bus (or misaligned pc: NOP packet)
// HOLD       | response captured while downstream stalled; replay it
// DISCARD    | redirected with a request in flight; drain and drop it
// WAIT_REDIR | misaligned packet consumed; idle until a redirect
module fetch_stage
    import pipes::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_stage_if.master   ibus,
    output fetch_out_t      out
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_hold_instr;
    // Address of the abandoned request, kept so the bus sees a stable
    // address while r_pc already tracks the newest redirect target.
    logic [XLEN-1:0] r_disc_addr;

    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [31:0]     w_hold_nxt;
    logic [XLEN-1:0] w_disc_nxt;
    logic            w_req_valid;
    logic [XLEN-1:0] w_req_addr;
    fetch_out_t      w_out;
    logic [XLEN-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + XLEN'(4);

    // State and PC registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= REQ;
            r_pc         <= PC_RESET;
            r_hold_instr <= '0;
            r_disc_addr  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_nxt;
            r_disc_addr  <= w_disc_nxt;
        end
    end

    // Next-state, bus request and output packet; redirect wins everywhere.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold_instr;
        w_disc_nxt  = r_disc_addr;
        w_req_valid = 1'b0;
        w_req_addr  = r_pc;
        w_out       = '0;

        unique case (r_state)
            REQ: begin
                if (r_pc[1:0] == 2'b00) begin
                    w_req_valid = 1'b1;
                    if (redirect_valid) begin
                        w_pc_nxt = redirect_pc;
                        if (!ibus.iresp_data_ok) begin
                            w_disc_nxt  = r_pc;
                            w_state_nxt = DISCARD;
                        end
                    end else if (ibus.iresp_data_ok) begin
                        if (en) begin
                            w_out    = make_pkt(r_pc, ibus.iresp_data, 1'b0);
                            w_pc_nxt = w_pc_inc;
                        end else begin
                            w_hold_nxt  = ibus.iresp_data;
                            w_state_nxt = HOLD;
                        end
                    end
                end else begin
                    if (redirect_valid) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_out = make_pkt(r_pc, INSTR_NOP, 1'b1);
                        if (en) begin
                            w_state_nxt = WAIT_REDIR;
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = REQ;
                end else begin
                    w_out = make_pkt(r_pc, r_hold_instr, 1'b0);
                    if (en) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = REQ;
                    end
                end
            end
            DISCARD: begin
                w_req_valid = 1'b1;
                w_req_addr  = r_disc_addr;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
                if (ibus.iresp_data_ok) begin
                    w_state_nxt = REQ;
                end
            end
            WAIT_REDIR: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = REQ;
            end
        endcase
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign ibus.ireq_valid = w_req_valid & reset;
    assign ibus.ireq_addr  = w_req_addr;
    assign out             = reset ? w_out : '0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import pipes::*;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_out_t  out;

    fetch_stage_if ibus ();

    fetch_stage #(.PC_RESET(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset_n),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus           (ibus),
        .out            (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rv;
        logic [63:0] rpc;
        logic        ok;
        logic [31:0] data;
        logic        e_req;
        logic [63:0] e_addr;
        logic        chk_out;
        logic        e_v;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t mk(logic en_i, logic rv_i, logic [63:0] rpc_i,
                                logic ok_i, logic [31:0] data_i,
                                logic e_req_i, logic [63:0] e_addr_i,
                                logic chk_i, logic e_v_i, logic [63:0] e_pc_i,
                                logic [31:0] e_instr_i, logic e_mis_i);
        vec_t v;
        v.en = en_i; v.rv = rv_i; v.rpc = rpc_i; v.ok = ok_i; v.data = data_i;
        v.e_req = e_req_i; v.e_addr = e_addr_i; v.chk_out = chk_i;
        v.e_v = e_v_i; v.e_pc = e_pc_i; v.e_instr = e_instr_i; v.e_mis = e_mis_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic en_i, input logic rv_i, input logic [63:0] rpc_i,
                         input logic ok_i, input logic [31:0] data_i);
        en                 = en_i;
        redirect_valid     = rv_i;
        redirect_pc        = rpc_i;
        ibus.iresp_data_ok = ok_i;
        ibus.iresp_data    = data_i;
    endtask

    initial begin
        //            en rv rpc            ok data         req addr      chk v  pc          instr          mis
        vq.push_back(mk(1, 0, 0,            1, 32'hA0,     1, B+64'h0,   1, 1, B+64'h0,   32'hA0,        0));
        vq.push_back(mk(1, 0, 0,            1, 32'hA1,     1, B+64'h4,   1, 1, B+64'h4,   32'hA1,        0));
        vq.push_back(mk(1, 0, 0,            1, 32'hA2,     1, B+64'h8,   1, 1, B+64'h8,   32'hA2,        0));
        vq.push_back(mk(0, 0, 0,            1, 32'hB3,     1, B+64'hC,   0, 0, 0,         0,             0));
        vq.push_back(mk(0, 0, 0,            0, 0,          0, 0,         1, 1, B+64'hC,   32'hB3,        0));
        vq.push_back(mk(0, 0, 0,            0, 0,          0, 0,         1, 1, B+64'hC,   32'hB3,        0));
        vq.push_back(mk(0, 0, 0,            0, 0,          0, 0,         1, 1, B+64'hC,   32'hB3,        0));
        vq.push_back(mk(1, 0, 0,            0, 0,          0, 0,         1, 1, B+64'hC,   32'hB3,        0));
        vq.push_back(mk(1, 0, 0,            0, 0,          1, B+64'h10,  1, 0, 0,         0,             0));
        vq.push_back(mk(1, 1, B+64'h100,    0, 0,          1, B+64'h10,  1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            0, 0,          1, B+64'h10,  1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            1, 32'hDEAD,   1, B+64'h10,  1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            1, 32'hC0,     1, B+64'h100, 1, 1, B+64'h100, 32'hC0,        0));
        vq.push_back(mk(1, 1, B+64'h300,    1, 32'hC1,     1, B+64'h104, 1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            0, 0,          1, B+64'h300, 1, 0, 0,         0,             0));
        vq.push_back(mk(1, 1, B+64'h102,    0, 0,          1, B+64'h300, 1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            1, 32'hBAD,    1, B+64'h300, 1, 0, 0,         0,             0));
        vq.push_back(mk(0, 0, 0,            0, 0,          0, 0,         1, 1, B+64'h102, 32'h0000_0013, 1));
        vq.push_back(mk(0, 0, 0,            0, 0,          0, 0,         1, 1, B+64'h102, 32'h0000_0013, 1));
        vq.push_back(mk(1, 0, 0,            0, 0,          0, 0,         1, 1, B+64'h102, 32'h0000_0013, 1));
        vq.push_back(mk(1, 0, 0,            1, 0,          0, 0,         1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            0, 0,          0, 0,         1, 0, 0,         0,             0));
        vq.push_back(mk(1, 1, B+64'h200,    0, 0,          0, 0,         1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            1, 32'hE0,     1, B+64'h200, 1, 1, B+64'h200, 32'hE0,        0));
        vq.push_back(mk(1, 1, B+64'h400,    0, 0,          1, B+64'h204, 1, 0, 0,         0,             0));
        vq.push_back(mk(1, 1, B+64'h500,    0, 0,          1, B+64'h204, 1, 0, 0,         0,             0));
        vq.push_back(mk(1, 1, B+64'h600,    1, 32'hBAD,    1, B+64'h204, 1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            1, 32'hF0,     1, B+64'h600, 1, 1, B+64'h600, 32'hF0,        0));
        vq.push_back(mk(0, 0, 0,            1, 32'h11,     1, B+64'h604, 0, 0, 0,         0,             0));
        vq.push_back(mk(0, 1, B+64'h700,    0, 0,          0, 0,         1, 0, 0,         0,             0));
        vq.push_back(mk(1, 0, 0,            1, 32'h22,     1, B+64'h700, 1, 1, B+64'h700, 32'h22,        0));

        reset_n = 1'b0;
        drive(1, 0, 0, 1, 32'h1234);
        #3;
        chk("rst_ireq_valid", 64'(ibus.ireq_valid), 64'h0);
        chk("rst_out_zero", 64'(out != '0), 64'h0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].en, vq[i].rv, vq[i].rpc, vq[i].ok, vq[i].data);
            #1;
            chk($sformatf("v%0d_ireq_valid", i), 64'(ibus.ireq_valid), 64'(vq[i].e_req));
            if (vq[i].e_req)
                chk($sformatf("v%0d_ireq_addr", i), ibus.ireq_addr, vq[i].e_addr);
            if (vq[i].chk_out) begin
                chk($sformatf("v%0d_out_valid", i), 64'(out.valid), 64'(vq[i].e_v));
                chk($sformatf("v%0d_out_mis", i), 64'(out.misalign), 64'(vq[i].e_mis));
                if (vq[i].e_v) begin
                    chk($sformatf("v%0d_out_pc", i), out.pc, vq[i].e_pc);
                    chk($sformatf("v%0d_out_instr", i), 64'(out.instr), 64'(vq[i].e_instr));
                end
            end
        end

        // pc wraps modulo 2^64 (state: REQ, pc = B+0x704)
        @(negedge clk);
        drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0);
        #1;
        chk("wrap_redir_valid", 64'(out.valid), 64'h0);
        @(negedge clk);
        drive(1, 0, 0, 1, 32'h33);
        #1;
        chk("wrap_addr_top", ibus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_out_pc", out.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_out_instr", 64'(out.instr), 64'h33);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        #1;
        chk("wrap_addr_zero", ibus.ireq_addr, 64'h0);

        // Async reset mid-DISCARD (state: REQ, pc = 0, request pending)
        @(negedge clk);
        drive(1, 1, B+64'h800, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        #1;
        chk("disc_ireq_valid", 64'(ibus.ireq_valid), 64'h1);
        chk("disc_ireq_addr", ibus.ireq_addr, 64'h0);
        #1;
        reset_n = 1'b0;
        drive(1, 0, 0, 1, 32'h55);
        #1;
        chk("async_rst_ireq_valid", 64'(ibus.ireq_valid), 64'h0);
        chk("async_rst_out_valid", 64'(out.valid), 64'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        #1;
        chk("restart_ireq_valid", 64'(ibus.ireq_valid), 64'h1);
        chk("restart_ireq_addr", ibus.ireq_addr, B);
        @(negedge clk);
        drive(1, 0, 0, 1, 32'h44);
        #1;
        chk("restart_out_valid", 64'(out.valid), 64'h1);
        chk("restart_out_pc", out.pc, B);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        #1;
        chk("restart_next_addr", ibus.ireq_addr, B+64'h4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one-outstanding-request fetches on the instruction bus.
- Presents a fetched {pc, instr} packet to the IF/ID register, honouring that register's enable (stall).
- Absorbs branch/jump redirects, including while a bus request is in flight.

Parameters:
- PC_RESET, 64'h8000_0000, PC value loaded on reset.
- XLEN, 64, width of PC and addresses.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- en  input  1  IF/ID register enable; 0 = downstream stalled, packet not consumed.
- redirect_valid  input  1  redirect from execute/commit this cycle.
- redirect_pc  input  XLEN  redirect target.
- ireq_valid  output  1  instruction-bus request valid.
- ireq_addr  output  XLEN  request address; held stable while ireq_valid=1 and no data_ok.
- iresp_data_ok  input  1  request completes this cycle; only meaningful when ireq_valid=1.
- iresp_data  input  32  instruction word, valid with iresp_data_ok.
- out  output  fetch_out_t  {valid, pc, instr, misalign} to the IF/ID register input; the integrator ties IF/ID flush_en to ~out.valid.

Behaviour:
- States: REQ, HOLD, DISCARD, WAIT_REDIR.
- Registers: pc, state, hold_instr.
- Reset (reset=0, async):
  - pc=PC_RESET, state=REQ.
  - While reset is asserted: ireq_valid=0 and out='0.
- REQ, pc[1:0]==0:
  - ireq_valid=1, ireq_addr=pc.
  - data_ok && en: out.valid=1, out.pc=pc, out.instr=iresp_data (combinational); pc<=pc+4; stay in REQ. Throughput is 1 instr/cycle when the bus answers in the request cycle.
  - data_ok && !en: hold_instr<=iresp_data; go to HOLD; pc unchanged.
  - No data_ok: out.valid=0; ireq_addr stays stable.
- REQ, pc[1:0]!=0 (misaligned):
  - ireq_valid=0.
  - out = {valid=1, pc, instr=NOP 32'h0000_0013, misalign=1}.
  - On en: go to WAIT_REDIR.
- HOLD:
  - ireq_valid=0; out.valid=1, out.instr=hold_instr, out.pc=pc.
  - On en: pc<=pc+4; go to REQ.
- WAIT_REDIR: ireq_valid=0, out.valid=0; leave only on redirect.
- DISCARD:
  - ireq_valid=1 with the old address; out.valid=0.
  - On data_ok: response dropped; go to REQ at the current pc.
- Redirect (redirect_valid=1) has the highest priority in every state. pc<=redirect_pc and out.valid=0 this cycle.
  - REQ without data_ok: go to DISCARD (the in-flight request cannot be withdrawn).
  - REQ with data_ok in the same cycle: data dropped; stay in REQ.
  - HOLD: buffer dropped; go to REQ.
  - WAIT_REDIR: go to REQ.
  - DISCARD without data_ok: pc overwritten by the newest target; stay in DISCARD.
  - DISCARD with data_ok: go to REQ with the new pc.
- pc+4 wraps modulo 2^XLEN; no overflow detection.
- Reset mid-request: state is abandoned immediately. The bus must tolerate ireq_valid dropping; any late data_ok is ignored because ireq_valid=0.
- out.misalign=0 in every case except misaligned REQ.

Decomposition:
- Package pipes holds:
  - fetch_state_t enum {REQ, HOLD, DISCARD, WAIT_REDIR}.
  - fetch_out_t packed struct {valid, pc[XLEN-1:0], instr[31:0], misalign}.
  - Constants INSTR_NOP=32'h13 and PC_RESET default.
- No sub-module. The IF/ID register is the existing generic pipeline register instantiated with T=fetch_out_t, outside this block.

Test Plan:
- Reset release, bus answers data_ok every cycle, en=1 -> ireq_addr 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive cycles; out.valid=1 each cycle with matching pc/instr.
- data_ok with en=0 for 3 cycles, then en=1 -> HOLD: ireq_valid=0, out.instr stable for 3 cycles; next request at pc+4 one cycle after en=1.
- Redirect to 0x8000_0100 while request for 0x8000_0010 is pending, data_ok 2 cycles later -> ireq_addr stays 0x8000_0010 until data_ok; that data is not presented (out.valid=0); next ireq_addr=0x8000_0100.
- redirect_valid and data_ok in the same REQ cycle -> out.valid=0; next ireq_addr=redirect_pc.
- Redirect to 0x8000_0102 -> no bus request; out = {1, 0x8000_0102, 0x13, misalign=1} until en; then idle until a redirect to 0x8000_0200 resumes fetch there.
- Assert reset (0) asynchronously mid-DISCARD -> ireq_valid and out.valid drop without waiting for clk; after release, fetch restarts at PC_RESET.
